// File: rtl/lsu_bus_if_pkg.sv
// Shared types and helpers for the LSU data-memory bus interface.
// Memop codes, FSM states, strobe bases and legality/strobe functions.
package lsu_bus_if_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_D  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam logic [2:0] OP_WU = 3'b110;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  function automatic logic f_legal(
    input logic       wr,
    input logic [2:0] op,
    input logic [2:0] off
  );
    logic ok;
    unique case (op[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    if (wr && op[2]) ok = 1'b0;
    if (!wr && op == 3'b111) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [7:0] f_strb(
    input logic [1:0] sz,
    input logic [2:0] off
  );
    logic [7:0] b;
    unique case (sz)
      2'b00:   b = STRB_B;
      2'b01:   b = STRB_H;
      2'b10:   b = STRB_W;
      default: b = STRB_D;
    endcase
    return b << off;
  endfunction

endpackage

// File: rtl/lsu_bus_if_ld_fmt.sv
// Load result formatter: picks the addressed byte/half/word
// out of the aligned doubleword and sign/zero-extends it.
module lsu_ld_fmt
  import lsu_bus_if_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_off,
  input  logic [2:0]      i_op,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_sh;

  assign w_sh = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = '0;
    unique case (i_op)
      OP_B:    o_data = {{56{w_sh[7]}}, w_sh[7:0]};
      OP_H:    o_data = {{48{w_sh[15]}}, w_sh[15:0]};
      OP_W:    o_data = {{32{w_sh[31]}}, w_sh[31:0]};
      OP_D:    o_data = w_sh;
      OP_BU:   o_data = {56'd0, w_sh[7:0]};
      OP_HU:   o_data = {48'd0, w_sh[15:0]};
      OP_WU:   o_data = {32'd0, w_sh[31:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_if.sv
// Single-outstanding valid/ready bus front end for the load/store stage.
// Stalls the stage for the whole access and returns formatted load data.
module lsu_bus_if
  import lsu_bus_if_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic            req_wr_i,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            stall_o,
  output logic            ld_valid_o,
  output logic [XLEN-1:0] ld_data_o,
  output logic            err_o,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [7:0]      mem_wstrb_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_addr;
  logic [2:0]      r_op;
  logic            r_wr;
  logic [XLEN-1:0] r_wdata;
  logic [7:0]      r_wstrb;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;
  logic            w_legal;
  logic            w_take;

  assign w_legal = f_legal(req_wr_i, req_op_i, req_addr_i[2:0]);
  assign w_take  = (r_state == S_IDLE) && req_valid_i && w_legal;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_take) w_next = S_REQ;
      S_REQ:  if (mem_ready_i) w_next = r_wr ? S_RESP : S_WAIT;
      S_WAIT: if (mem_rvalid_i) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_op    <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == S_IDLE) && req_valid_i && !w_legal;
      if (w_take) begin
        r_addr  <= req_addr_i;
        r_op    <= req_op_i;
        r_wr    <= req_wr_i;
        r_wdata <= req_wdata_i << {req_addr_i[2:0], 3'b000};
        r_wstrb <= f_strb(req_op_i[1:0], req_addr_i[2:0]);
      end
      if (r_state == S_WAIT && mem_rvalid_i) r_rdata <= mem_rdata_i;
    end
  end

  // RESP drops stall so the stage retires the op at the end of that cycle.
  assign stall_o     = w_take || r_state == S_REQ || r_state == S_WAIT;
  assign ld_valid_o  = (r_state == S_RESP) && !r_wr;
  assign err_o       = r_err;
  assign mem_valid_o = (r_state == S_REQ);
  assign mem_we_o    = r_wr;
  assign mem_addr_o  = {r_addr[XLEN-1:3], 3'b000};
  assign mem_wdata_o = r_wdata;
  assign mem_wstrb_o = r_wstrb;

  lsu_ld_fmt u_fmt (
    .i_rdata (r_rdata),
    .i_off   (r_addr[2:0]),
    .i_op    (r_op),
    .o_data  (ld_data_o)
  );

endmodule

// File: tb/tb_lsu_bus_if.sv
// Randomized bench for lsu_bus_if with a transaction-timeline model.
// Directed cases pin the model and the DUT to literal values.
module tb_lsu_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_wr_i;
  logic [2:0]  req_op_i;
  logic [63:0] req_addr_i, req_wdata_i;
  logic        stall_o, ld_valid_o, err_o;
  logic [63:0] ld_data_o;
  logic        mem_valid_o, mem_ready_i, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  always #5 clk = ~clk;

  lsu_bus_if dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_wr_i(req_wr_i),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .stall_o(stall_o), .ld_valid_o(ld_valid_o),
    .ld_data_o(ld_data_o), .err_o(err_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_mv = 0;
  int n_stall = 0;
  int n_ldv = 0;
  logic [63:0] last_ld = '0;

  logic        chk = 1'b0;
  logic        e_stall, e_mv, e_we, e_ldv, e_err;
  logic [63:0] e_addr, e_wdata, e_ld;
  logic [7:0]  e_strb;

  task automatic cmp(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  function automatic logic m_legal(input logic wr, input logic [2:0] op,
                                   input logic [63:0] a);
    int nb;
    if (wr && op >= 3'd4) return 1'b0;
    if (!wr && op == 3'd7) return 1'b0;
    nb = 1 << op[1:0];
    return (int'(a[2:0]) % nb) == 0;
  endfunction

  function automatic logic [63:0] m_fmt(input logic [63:0] rd,
                                        input logic [2:0] off,
                                        input logic [2:0] op);
    int nb;
    logic [63:0] mask, v;
    nb = 1 << op[1:0];
    mask = (nb == 8) ? ~64'd0 : (64'd1 << (8 * nb)) - 64'd1;
    v = (rd >> (8 * off)) & mask;
    if (op < 3'd4 && nb < 8 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] m_strb(input logic [2:0] op,
                                        input logic [2:0] off);
    logic [15:0] s;
    s = 16'((1 << (1 << op[1:0])) - 1) << off;
    return s[7:0];
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      cmp("stall", 64'(stall_o), 64'(e_stall));
      cmp("mem_valid", 64'(mem_valid_o), 64'(e_mv));
      cmp("ld_valid", 64'(ld_valid_o), 64'(e_ldv));
      cmp("err", 64'(err_o), 64'(e_err));
      if (e_mv) begin
        cmp("mem_we", 64'(mem_we_o), 64'(e_we));
        cmp("mem_addr", mem_addr_o, e_addr);
        cmp("mem_wdata", mem_wdata_o, e_wdata);
        cmp("mem_wstrb", 64'(mem_wstrb_o), 64'(e_strb));
      end
      if (e_ldv) cmp("ld_data", ld_data_o, e_ld);
    end
    if (mem_valid_o) n_mv++;
    if (stall_o) n_stall++;
    if (ld_valid_o) begin
      n_ldv++;
      last_ld = ld_data_o;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setx(input logic s, input logic mv,
                      input logic ldv, input logic er);
    e_stall = s;
    e_mv = mv;
    e_ldv = ldv;
    e_err = er;
  endtask

  task automatic junk();
    mem_rvalid_i = 1'($urandom % 2);
    mem_rdata_i = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid_i = 1'b0;
      req_wr_i = 1'($urandom % 2);
      req_op_i = 3'($urandom);
      req_addr_i = {$urandom, $urandom};
      mem_ready_i = 1'b0;
      junk();
      setx(0, 0, 0, 0);
      cyc();
    end
  endtask

  task automatic run_op(input logic wr, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rd, input int dr,
                        input int dv);
    logic lg;
    logic [2:0] off;
    lg = m_legal(wr, op, a);
    off = a[2:0];
    req_valid_i = 1'b1;
    req_wr_i = wr;
    req_op_i = op;
    req_addr_i = a;
    req_wdata_i = wd;
    mem_ready_i = 1'b0;
    junk();
    setx(lg, 0, 0, 0);
    cyc();
    if (!lg) begin
      req_valid_i = 1'b0;
      junk();
      setx(0, 0, 0, 1);
      cyc();
      return;
    end
    e_we = wr;
    e_addr = a & ~64'd7;
    e_wdata = wd << (8 * off);
    e_strb = m_strb(op, off);
    for (int j = 0; j <= dr; j++) begin
      mem_ready_i = (j == dr);
      junk();
      setx(1, 1, 0, 0);
      cyc();
    end
    mem_ready_i = 1'b0;
    if (!wr) begin
      for (int j = 0; j <= dv; j++) begin
        mem_rvalid_i = (j == dv);
        mem_rdata_i = (j == dv) ? rd : {$urandom, $urandom};
        setx(1, 0, 0, 0);
        cyc();
      end
    end
    junk();
    e_ld = m_fmt(rd, off, op);
    setx(0, 0, !wr, 0);
    cyc();
  endtask

  int s_mv, s_st, s_ld;

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0;
    req_wr_i = 1'b0;
    req_op_i = '0;
    req_addr_i = '0;
    req_wdata_i = '0;
    mem_ready_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    cyc();
    cyc();
    #3;
    cmp("rst_stall", 64'(stall_o), 64'd0);
    cmp("rst_ld_valid", 64'(ld_valid_o), 64'd0);
    cmp("rst_err", 64'(err_o), 64'd0);
    cmp("rst_mem_valid", 64'(mem_valid_o), 64'd0);
    cmp("rst_mem_we", 64'(mem_we_o), 64'd0);
    cmp("rst_ld_data", ld_data_o, 64'd0);
    cmp("rst_mem_addr", mem_addr_o, 64'd0);
    cmp("rst_mem_wdata", mem_wdata_o, 64'd0);
    cmp("rst_mem_wstrb", 64'(mem_wstrb_o), 64'd0);
    cyc();
    rst = 1'b0;

    cmp("pin_fmt_lb", m_fmt(64'hF000_0000, 3'd3, 3'b000),
        64'hFFFF_FFFF_FFFF_FFF0);
    cmp("pin_fmt_lbu", m_fmt(64'hF000_0000, 3'd3, 3'b100), 64'hF0);
    cmp("pin_strb_sh6", 64'(m_strb(3'b001, 3'd6)), 64'hC0);
    cmp("pin_legal_lw2", 64'(m_legal(1'b0, 3'b010, 64'h80000002)), 64'd0);

    chk = 1'b1;
    idle(2);

    s_st = n_stall;
    run_op(0, 3'b011, 64'h80000008, 64'd0, 64'h1122334455667788, 0, 0);
    cmp("lit_ld", last_ld, 64'h1122334455667788);
    cmp("lit_ld_stall", 64'(n_stall - s_st), 64'd3);
    idle(1);

    run_op(0, 3'b000, 64'h80000003, 64'd0, 64'hF000_0000, 0, 1);
    cmp("lit_lb", last_ld, 64'hFFFF_FFFF_FFFF_FFF0);
    run_op(0, 3'b100, 64'h80000003, 64'd0, 64'hF000_0000, 1, 0);
    cmp("lit_lbu", last_ld, 64'hF0);
    idle(1);

    s_st = n_stall;
    s_mv = n_mv;
    run_op(1, 3'b001, 64'h80000006, 64'hABCD, 64'd0, 3, 0);
    cmp("lit_sh_stall", 64'(n_stall - s_st), 64'd5);
    cmp("lit_sh_mv", 64'(n_mv - s_mv), 64'd4);
    idle(1);

    s_mv = n_mv;
    s_st = n_stall;
    run_op(0, 3'b010, 64'h80000002, 64'd0, 64'd0, 0, 0);
    cmp("lit_lw_mis_mv", 64'(n_mv - s_mv), 64'd0);
    cmp("lit_lw_mis_stall", 64'(n_stall - s_st), 64'd0);
    idle(1);

    // reset while waiting for read data
    s_ld = n_ldv;
    req_valid_i = 1'b1;
    req_wr_i = 1'b0;
    req_op_i = 3'b011;
    req_addr_i = 64'h80000010;
    req_wdata_i = '0;
    mem_rvalid_i = 1'b0;
    setx(1, 0, 0, 0);
    cyc();
    mem_ready_i = 1'b1;
    e_we = 1'b0;
    e_addr = 64'h80000010;
    e_wdata = '0;
    e_strb = 8'hFF;
    setx(1, 1, 0, 0);
    cyc();
    mem_ready_i = 1'b0;
    setx(1, 0, 0, 0);
    cyc();
    rst = 1'b1;
    setx(1, 0, 0, 0);
    cyc();
    rst = 1'b0;
    req_valid_i = 1'b0;
    setx(0, 0, 0, 0);
    cyc();
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
    cyc();
    mem_rvalid_i = 1'b0;
    cyc();
    cmp("rst_wait_no_ld", 64'(n_ldv - s_ld), 64'd0);

    s_mv = n_mv;
    run_op(1, 3'b011, 64'h80000020, 64'h0123456789ABCDEF, 64'd0, 0, 0);
    run_op(0, 3'b110, 64'h80000024, 64'd0, 64'h89ABCDEF_01234567, 0, 0);
    cmp("b2b_mv", 64'(n_mv - s_mv), 64'd2);
    cmp("lit_lwu", last_ld, 64'h89ABCDEF);
    idle(1);

    for (int k = 0; k < 200; k++) begin
      logic wr;
      logic [2:0] op, low;
      logic [63:0] a;
      wr = 1'($urandom % 2);
      op = 3'($urandom);
      low = 3'($urandom);
      if ($urandom % 4 != 0)
        low = low & ~3'((1 << op[1:0]) - 1);
      a = 64'h80000000 | 64'($urandom & 32'hFF8) | 64'(low);
      run_op(wr, op, a, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom % 4), int'($urandom % 4));
      idle(int'($urandom % 3));
    end

    idle(2);
    chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_bus_if.md
# lsu_bus_if

Bus interface unit sitting directly downstream of the load/store stage: it accepts one decoded memory operation per instruction (load or store, funct3 memop, byte address, store data), drives it onto a single-outstanding valid/ready data-memory bus, stalls the load/store stage until the access completes, and returns the byte-lane-extracted, sign/zero-extended load result for writeback. It replaces the simulation-only direct memory access path with a cycle-accurate handshake usable with a cache or SoC bus.

## Interface
- XLEN, 64, data/address width (only 64 supported)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  load/store stage holds a memory op this cycle
- req_wr_i  in  1  1 = store, 0 = load
- req_op_i  in  3  funct3 memop: lb 000, lh 001, lw 010, ld 011, lbu 100, lhu 101, lwu 110; sb/sh/sw/sd 000–011
- req_addr_i  in  XLEN  byte address
- req_wdata_i  in  XLEN  store data, right-aligned
- stall_o  out  1  hold load/store stage and everything upstream
- ld_valid_o  out  1  one-cycle pulse, ld_data_o valid
- ld_data_o  out  XLEN  formatted load result
- err_o  out  1  one-cycle pulse, misaligned or illegal op (no bus access made)
- mem_valid_o  out  1  bus request valid
- mem_ready_i  in  1  bus accepts request
- mem_we_o  out  1  request is a write
- mem_addr_o  out  XLEN  req address with [2:0] forced to 0
- mem_wdata_o  out  XLEN  store data shifted left by 8*addr[2:0]
- mem_wstrb_o  out  8  byte strobes
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  XLEN  aligned 8-byte read data

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: if req_valid_i and op legal/aligned, register addr, op, wr, shifted wdata, strobes -> REQ. If misaligned (h: addr[0]≠0; w: addr[1:0]≠0; d: addr[2:0]≠0) or illegal (load 111, store op[2]=1): err_o=1 next cycle, stay IDLE, no bus activity.
- REQ: mem_valid_o=1, bus fields from registers, held stable until mem_ready_i. On accept: store -> RESP, load -> WAIT.
- WAIT: on mem_rvalid_i, register mem_rdata_i -> RESP.
- RESP: ld_valid_o=1 for loads (0 for stores), ld_data_o from registered rdata; -> IDLE. req_valid_i ignored in RESP (it still shows the completing instruction).
- Strobes: b 0x01, h 0x03, w 0x0F, d 0xFF, each shifted left by addr[2:0].
- Load format: byte/half/word selected by addr[2:0] from rdata, sign-extended for lb/lh/lw, zero-extended for lbu/lhu/lwu, ld passes 64 bits.
- stall_o = (IDLE & req_valid_i & legal) | REQ | WAIT. Low in RESP so the stage advances at the end of RESP.
- mem_rvalid_i outside WAIT ignored. At most one outstanding request.

## Timing
- Reset values: state IDLE; stall_o follows its equation (0 with req_valid_i=0); ld_valid_o, err_o, mem_valid_o, mem_we_o 0; ld_data_o, mem_addr_o, mem_wdata_o 0; mem_wstrb_o 0.
- Load, ready and rvalid at earliest: IDLE (T0) -> REQ (T1, accepted) -> WAIT (T2, rvalid) -> RESP (T3, ld_valid_o). stall_o high T0–T2.
- Store, ready at T1: RESP at T2, stall_o high T0–T1.
- Every extra cycle of mem_ready_i or mem_rvalid_i low adds one stall cycle.
- err_o pulses in T1 after an illegal op sampled in T0. stall_o stays low.
- rst asserted in any state: next cycle IDLE, mem_valid_o=0, any pending response dropped. Bus is reset together with this block.

## Structure
- Add memop codes, state encodings and strobe base values to defines.v, next to the existing load/store macros.
- One combinational sub-module, lsu_ld_fmt (rdata, addr[2:0], op -> ld_data). The FSM, request registers and strobe/shift generation stay in lsu_bus_if.

## Test plan
- ld 0x80000008, ready immediate, rvalid next cycle with rdata 0x1122334455667788 -> ld_valid_o at T3, ld_data_o 0x1122334455667788, stall_o high T0–T2.
- lb 0x80000003, rdata 0x00000000F0000000 -> ld_data_o 0xFFFFFFFFFFFFFFF0. lbu same -> 0xF0.
- sh 0x80000006, wdata 0xABCD, ready held low 3 cycles -> mem_addr_o 0x80000000, mem_wstrb_o 0xC0, mem_wdata_o 0xABCD000000000000 stable throughout, stall_o high 5 cycles.
- lw 0x80000002 -> err_o pulse, mem_valid_o never asserted, stall_o 0.
- rst pulsed while in WAIT -> IDLE next cycle, a later mem_rvalid_i produces no ld_valid_o.
- Back-to-back sd then lwu, no idle cycle between -> two separate bus requests, no duplicate issue of the sd in its RESP cycle.
